// File: rtl/inst_queue.sv
// Instruction buffer between fetch and decode: an in-order circular queue of {PC,Inst}
// packets with valid/ready handshakes on both sides and a synchronous flush.
module inst_queue #(
   parameter  int DEPTH  = 4,
   parameter  int DATA_W = 64,
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              excp_flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [31:0]       out_pc,
   output logic [CNT_W-1:0]  count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
   logic [CNT_W-1:0]  count_r, count_nxt_s;
   logic              in_ready_r, out_valid_r;
   logic              flush_s, push_s, pop_s;

   // Both redirect sources behave identically; a flush kills any same-cycle transfer.
   assign flush_s = flush | excp_flush;
   assign push_s  = in_valid & in_ready_r & ~flush_s;
   assign pop_s   = out_valid_r & out_ready & ~flush_s;

   // Next-state for pointers and occupancy.
   always_comb begin
      wr_ptr_nxt_s = wr_ptr_r;
      rd_ptr_nxt_s = rd_ptr_r;
      count_nxt_s  = count_r;
      if (flush_s) begin
         wr_ptr_nxt_s = {PTR_W{1'b0}};
         rd_ptr_nxt_s = {PTR_W{1'b0}};
         count_nxt_s  = {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
         end else begin
            wr_ptr_nxt_s = wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
         end else begin
            rd_ptr_nxt_s = rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
         endcase
      end
   end

   // State registers; the handshake flags are registered from the next occupancy.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_r    <= {PTR_W{1'b0}};
         rd_ptr_r    <= {PTR_W{1'b0}};
         count_r     <= {CNT_W{1'b0}};
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         wr_ptr_r    <= wr_ptr_nxt_s;
         rd_ptr_r    <= rd_ptr_nxt_s;
         count_r     <= count_nxt_s;
         in_ready_r  <= (count_nxt_s != CNT_W'(DEPTH));
         out_valid_r <= (count_nxt_s != {CNT_W{1'b0}});
      end
   end

   // Packet storage; a flush leaves contents untouched.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {DATA_W{1'b0}};
         end
      end else if (push_s) begin
         mem_r[wr_ptr_r] <= in_data;
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_data  = mem_r[rd_ptr_r];
   assign out_pc    = out_data[DATA_W-1 -: 32];
   assign count     = count_r;

endmodule
